// File: rtl/reg_file_master_pkg.sv
// Shared types for the register-file master: opcodes, FSM states, instruction layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_master_pkg;

    localparam int DW = 16;     // register-file word width
    localparam int AW = 3;      // register address width (8 registers)
    localparam int IW = 16;     // instruction word width

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_RD  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Field layout: op[15:13] dst[12:10] src_a[9:7] src_b[6:4] low[3:0].
    // LDI reuses bits [7:0] as imm8, overlapping src_a/src_b/low.
    typedef struct packed {
        op_t            op;
        logic [AW-1:0]  dst;
        logic [AW-1:0]  src_a;
        logic [AW-1:0]  src_b;
        logic [3:0]     low;
    } instr_t;

    function automatic logic [7:0] instr_imm8(input instr_t i);
        logic [IW-1:0] w;
        w = i;
        return w[7:0];
    endfunction

    // State entered from IDLE when an instruction is accepted.
    function automatic state_t dispatch(input op_t op);
        case (op)
            OP_NOP:  return ST_IDLE;
            OP_LDI:  return ST_WRITE;
            default: return ST_READ;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_master_if.sv
// Port bundle between the register-file master and its environment: instruction
// stream, register-file port, result stream and busy flag.
// Latency/backpressure: defined by the master; in_* and res_* are valid/ready.
interface reg_file_master_if;
    import reg_file_master_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  in_instr;
    logic           wr;
    logic [AW-1:0]  rd_addr_a;
    logic [AW-1:0]  rd_addr_b;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  d_in;
    logic [DW-1:0]  d_out_a;
    logic [DW-1:0]  d_out_b;
    logic           res_valid;
    logic           res_ready;
    logic [DW-1:0]  res_data;
    logic           busy;

    modport master (
        input  in_valid, in_instr, d_out_a, d_out_b, res_ready,
        output in_ready, wr, rd_addr_a, rd_addr_b, wr_addr, d_in,
               res_valid, res_data, busy
    );

    modport slave (
        output in_valid, in_instr, d_out_a, d_out_b, res_ready,
        input  in_ready, wr, rd_addr_a, rd_addr_b, wr_addr, d_in,
               res_valid, res_data, busy
    );

endinterface

// File: rtl/reg_file_master_alu16.sv
// alu16: 16-bit combinational ALU for the register-file datapath (op, a, b, imm8 -> result).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu16
    import reg_file_master_pkg::*;
(
    input  op_t            op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [7:0]     imm8,
    output logic [DW-1:0]  result
);

    // Arithmetic wraps modulo 2^16; carry/borrow are dropped by the width.
    always_comb begin
        result = '0;
        case (op)
            OP_NOP:  result = '0;
            OP_LDI:  result = {8'h00, imm8};
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_RD:   result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_master.sv
// reg_file_master: one-at-a-time instruction initiator for an 8x16 register file.
// Latency: ALU 3 cycles/instr (read, write, idle), LDI 2, NOP 1, RD 2 + result stall.
// Backpressure: in_ready low outside IDLE; RD result held in RESP until res_ready.
// Ports: clk, reset (async active-low), rf (master modport: instruction in, rf port,
// result out, busy). All outputs are registered, decoded from the next state.
module reg_file_master
    import reg_file_master_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    reg_file_master_if.master rf
);

    state_t         state;
    state_t         state_nxt;
    instr_t         instr_q;
    instr_t         instr_sel;
    logic           accept;
    logic [DW-1:0]  alu_res;

    // In IDLE the ALU and address fields come straight from the offered word so
    // LDI can write one cycle after the handshake; afterwards from the capture.
    assign instr_sel = (state == ST_IDLE) ? instr_t'(rf.in_instr) : instr_q;
    assign accept    = (state == ST_IDLE) && rf.in_valid;

    alu16 u_alu (
        .op     (instr_sel.op),
        .a      (rf.d_out_a),
        .b      (rf.d_out_b),
        .imm8   (instr_imm8(instr_sel)),
        .result (alu_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rf.in_valid) begin
                    state_nxt = dispatch(instr_sel.op);
                end
            end
            ST_READ: begin
                state_nxt = (instr_q.op == OP_RD) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end
            ST_RESP: begin
                // res_valid is high for the whole of RESP.
                if (rf.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output registers. Control outputs follow the state being entered so they
    // line up with it; address/data registers only load when their state is
    // entered and otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q      <= '0;
            rf.in_ready  <= 1'b1;
            rf.busy      <= 1'b0;
            rf.wr        <= 1'b0;
            rf.res_valid <= 1'b0;
            rf.rd_addr_a <= '0;
            rf.rd_addr_b <= '0;
            rf.wr_addr   <= '0;
            rf.d_in      <= '0;
            rf.res_data  <= '0;
        end else begin
            rf.in_ready  <= (state_nxt == ST_IDLE);
            rf.busy      <= (state_nxt != ST_IDLE);
            rf.wr        <= (state_nxt == ST_WRITE);
            rf.res_valid <= (state_nxt == ST_RESP);

            if (accept) begin
                instr_q <= instr_t'(rf.in_instr);
            end

            if (accept && (state_nxt == ST_READ)) begin
                rf.rd_addr_a <= instr_sel.src_a;
                rf.rd_addr_b <= instr_sel.src_b;
            end

            // WRITE always lasts one cycle, so a next state of WRITE is an entry.
            // From READ, d_out_* are the live register values for src_a/src_b.
            if (state_nxt == ST_WRITE) begin
                rf.wr_addr <= instr_sel.dst;
                rf.d_in    <= alu_res;
            end

            if ((state == ST_READ) && (state_nxt == ST_RESP)) begin
                rf.res_data <= alu_res;
            end
        end
    end

endmodule
